// File: rtl/cfg_loader_pkg.sv
// cfg_loader_pkg
//   Shared definitions for the configuration chain loader:
//   - cfg_state_t  : loader FSM state encoding
//   - CFG_CRC_POLY : CRC-8 polynomial (x^8 + x^2 + x + 1)
//   - CFG_CRC_INIT : CRC-8 start value
//   - crc8_step    : one MSB-first serial CRC-8 update
package cfg_loader_pkg;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LOAD   = 2'd1,
      ST_VERIFY = 2'd2,
      ST_DONE   = 2'd3
   } cfg_state_t;

   localparam logic [7:0] CFG_CRC_POLY = 8'h07;
   localparam logic [7:0] CFG_CRC_INIT = 8'h00;

   // Serial update: the incoming bit is folded in at the MSB end.
   function automatic logic [7:0] crc8_step(input logic [7:0] crc, input logic bit_in);
      logic fb;
      fb = crc[7] ^ bit_in;
      crc8_step = {crc[6:0], 1'b0} ^ (fb ? CFG_CRC_POLY : 8'h00);
   endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// cfg_crc8_serial
//   One-bit-per-cycle CRC-8 accumulator.
//   Ports:
//     clk    in  : clock
//     srst   in  : synchronous active-high reset (returns to CFG_CRC_INIT)
//     clr    in  : synchronous clear to CFG_CRC_INIT (wins over en)
//     en     in  : fold bit_in into the CRC this cycle
//     bit_in in  : serial data bit
//     crc    out : current CRC value (registered)
module cfg_crc8_serial
   import cfg_loader_pkg::*;
(
   input  logic       clk,
   input  logic       srst,
   input  logic       clr,
   input  logic       en,
   input  logic       bit_in,
   output logic [7:0] crc
);

   logic [7:0] crc_reg;

   always_ff @(posedge clk) begin
      if (srst || clr) begin
         crc_reg <= CFG_CRC_INIT;
      end else if (en) begin
         crc_reg <= crc8_step(crc_reg, bit_in);
      end
   end

   assign crc = crc_reg;

endmodule

// File: rtl/cfg_chain_loader.sv
// cfg_chain_loader
//   Serial configuration master for the fabric programming scan chain.
//   Host words arrive over a valid/ready stream and are shifted LSB first
//   onto the chain; exactly CHAIN_LEN bits are shifted per load.
//   Optional readback (macro CFG_READBACK_EN): after loading, the chain is
//   rotated once through itself while a CRC of the returning bits is
//   compared against a CRC of the loaded bits.
//   Parameters: CHAIN_LEN (chain bits, >=1), WORD_W (host word width, >=1)
//   Ports:
//     prog_clk   in  : clock, also clocks the chain
//     prog_rst   in  : synchronous active-high reset
//     start      in  : begin a load (honoured only in IDLE/DONE)
//     word_data  in  : configuration word, LSB shifted first
//     word_valid in  : host word valid
//     word_ready out : word accepted on word_valid && word_ready
//     chain_din  out : to first tile prog_in
//     chain_en   out : chain prog_en, one shift per cycle while high
//     chain_dout in  : from last tile prog_out (registered in the chain)
//     busy       out : load or verify in progress
//     done       out : sticky completion flag, cleared by start
//     error      out : sticky readback CRC mismatch, 0 without readback
module cfg_chain_loader
   import cfg_loader_pkg::*;
#(
   parameter int CHAIN_LEN = 48,
   parameter int WORD_W    = 8
) (
   input  logic              prog_clk,
   input  logic              prog_rst,
   input  logic              start,
   input  logic [WORD_W-1:0] word_data,
   input  logic              word_valid,
   output logic              word_ready,
   output logic              chain_din,
   output logic              chain_en,
   input  logic              chain_dout,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam int CNT_W = $clog2(CHAIN_LEN + 1);
   localparam int WB_W  = $clog2(WORD_W + 1);

   cfg_state_t        state_reg;
   logic [CNT_W-1:0]  bit_cnt_reg;    // bits left to shift (LOAD) or rotate (VERIFY)
   logic [WB_W-1:0]   word_bits_reg;  // unshifted bits left in the holding register
   logic [WORD_W-1:0] shift_reg;
   logic              busy_reg;
   logic              done_reg;

   logic in_load;
   logic in_verify;
   logic shift_go;
   logic take_word;
   logic start_ok;

   assign in_load  = (state_reg == ST_LOAD);
   assign start_ok = start && ((state_reg == ST_IDLE) || (state_reg == ST_DONE));
   assign shift_go = in_load && (word_bits_reg != '0);

   // Refill while empty, or overlap with the last bit of the current word
   // so consecutive words leave no gap on the chain.
   assign word_ready = in_load &&
                       ((word_bits_reg == '0) ||
                        ((word_bits_reg == WB_W'(1)) && (bit_cnt_reg > CNT_W'(1))));
   assign take_word  = word_ready && word_valid;

`ifdef CFG_READBACK_EN
   logic [7:0] crc_load;
   logic [7:0] crc_rb;
   logic       error_reg;

   assign in_verify = (state_reg == ST_VERIFY);

   cfg_crc8_serial u_crc_load (
      .clk    (prog_clk),
      .srst   (prog_rst),
      .clr    (start_ok),
      .en     (shift_go),
      .bit_in (shift_reg[0]),
      .crc    (crc_load)
   );

   cfg_crc8_serial u_crc_rb (
      .clk    (prog_clk),
      .srst   (prog_rst),
      .clr    (start_ok),
      .en     (in_verify),
      .bit_in (chain_dout),
      .crc    (crc_rb)
   );

   // During readback the chain output is fed straight back to its input.
   assign chain_din = in_verify ? chain_dout : shift_reg[0];
   assign error     = error_reg;
`else
   logic unused_chain_dout;

   assign unused_chain_dout = chain_dout;
   assign in_verify         = 1'b0;
   assign chain_din         = shift_reg[0];
   assign error             = 1'b0;
`endif

   assign chain_en = shift_go || in_verify;
   assign busy     = busy_reg;
   assign done     = done_reg;

   always_ff @(posedge prog_clk) begin
      if (prog_rst) begin
         state_reg     <= ST_IDLE;
         bit_cnt_reg   <= '0;
         word_bits_reg <= '0;
         shift_reg     <= '0;
         busy_reg      <= 1'b0;
         done_reg      <= 1'b0;
`ifdef CFG_READBACK_EN
         error_reg     <= 1'b0;
`endif
      end else begin
         case (state_reg)
            ST_IDLE, ST_DONE: begin
               if (start) begin
                  state_reg     <= ST_LOAD;
                  bit_cnt_reg   <= CNT_W'(CHAIN_LEN);
                  word_bits_reg <= '0;
                  busy_reg      <= 1'b1;
                  done_reg      <= 1'b0;
`ifdef CFG_READBACK_EN
                  error_reg     <= 1'b0;
`endif
               end
            end

            ST_LOAD: begin
               if (shift_go) begin
                  shift_reg     <= shift_reg >> 1;
                  word_bits_reg <= word_bits_reg - WB_W'(1);
                  bit_cnt_reg   <= bit_cnt_reg - CNT_W'(1);
                  if (bit_cnt_reg == CNT_W'(1)) begin
                     // Last chain bit: drop the unused tail of the final word
                     // so chain_din rests at 0.
                     word_bits_reg <= '0;
                     shift_reg     <= '0;
`ifdef CFG_READBACK_EN
                     state_reg     <= ST_VERIFY;
                     bit_cnt_reg   <= CNT_W'(CHAIN_LEN);
`else
                     state_reg     <= ST_DONE;
                     busy_reg      <= 1'b0;
                     done_reg      <= 1'b1;
`endif
                  end
               end
               // Cannot coincide with the final shift: word_ready is low then.
               if (take_word) begin
                  shift_reg     <= word_data;
                  word_bits_reg <= WB_W'(WORD_W);
               end
            end

`ifdef CFG_READBACK_EN
            ST_VERIFY: begin
               bit_cnt_reg <= bit_cnt_reg - CNT_W'(1);
               if (bit_cnt_reg == CNT_W'(1)) begin
                  state_reg <= ST_DONE;
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  // Include the bit arriving this cycle in the readback CRC.
                  error_reg <= (crc8_step(crc_rb, chain_dout) != crc_load);
               end
            end
`endif

            default: begin
               state_reg <= ST_IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cfg_chain_loader.sv
// tb_cfg_chain_loader
//   Randomized bench for cfg_chain_loader with CHAIN_LEN=20, WORD_W=8.
//   Contains a behavioural 20-flop chain attached to chain_din/chain_en/
//   chain_dout and a reference built from the load rules: the first
//   CHAIN_LEN bits of the word stream, LSB first, end up in the chain.
//   Compile with CFG_READBACK_EN to exercise the readback pass.
module tb_cfg_chain_loader;

   localparam int L  = 20;
   localparam int W  = 8;
   localparam int NW = (L + W - 1) / W;
`ifdef CFG_READBACK_EN
   localparam int RB = 1;
`else
   localparam int RB = 0;
`endif

   logic         prog_clk = 1'b0;
   logic         prog_rst;
   logic         start;
   logic [W-1:0] word_data;
   logic         word_valid;
   logic         word_ready;
   logic         chain_din;
   logic         chain_en;
   logic         chain_dout;
   logic         busy;
   logic         done;
   logic         error;

   int total = 0;
   int bad   = 0;

   // Behavioural scan chain: index 0 is the first tile.
   logic [L-1:0] chain_q = '0;
   int           en_total = 0;
   logic         en_clr = 1'b0;
   logic         inject_flip = 1'b0;

   always #5 prog_clk = ~prog_clk;

   cfg_chain_loader #(.CHAIN_LEN(L), .WORD_W(W)) u_dut (
      .prog_clk   (prog_clk),
      .prog_rst   (prog_rst),
      .start      (start),
      .word_data  (word_data),
      .word_valid (word_valid),
      .word_ready (word_ready),
      .chain_din  (chain_din),
      .chain_en   (chain_en),
      .chain_dout (chain_dout),
      .busy       (busy),
      .done       (done),
      .error      (error)
   );

   assign chain_dout = chain_q[L-1];

   always @(posedge prog_clk) begin
      if (en_clr) begin
         en_total <= 0;
      end else if (chain_en) begin
         en_total <= en_total + 1;
      end
      if (chain_en) begin
         chain_q <= {chain_q[L-2:0], chain_din};
         // Corrupt one bit passing flop 7 during the readback pass.
         if (inject_flip && en_total == L + 3) begin
            chain_q[7] <= ~chain_q[6];
         end
      end
   end

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", tag, got, want);
      end
   endtask

   // One full load. stall_len: cycles word_valid is withheld after the first
   // word; inject: corrupt chain during readback; mid_start: pulse start in LOAD.
   task automatic run_load(input int n, input bit fixed, input int stall_len,
                           input bit inject, input bit mid_start);
      logic [W-1:0] words [NW];
      logic [L-1:0] exp_bits;
      logic [L-1:0] exp_img;
      logic [L-1:0] din_seq;
      logic [W-1:0] wtmp;
      int c, idx, din_n, en_n, done_c, stall_left, exp_done;

      for (int i = 0; i < NW; i++) words[i] = W'($urandom);
      if (fixed) begin
         words[0] = 8'hA5;
         words[1] = 8'h3C;
         words[2] = 8'h0F;
      end
      for (int k = 0; k < L; k++) begin
         wtmp = words[k / W];
         exp_bits[k]       = wtmp[k % W];
         exp_img[L-1-k]    = wtmp[k % W];
      end
      exp_done = L + 2 + stall_len + RB * L;

      inject_flip = inject;
      din_seq = '0;
      idx = 0; din_n = 0; en_n = 0; done_c = 0; stall_left = 0;

      @(negedge prog_clk);
      start = 1'b1; en_clr = 1'b1; word_valid = 1'b0;
      @(negedge prog_clk);
      start = 1'b0; en_clr = 1'b0;
      c = 1;
      check_val("busy_c1", busy, 1);
      check_val("done_clr", done, 0);
      check_val("ready_c1", word_ready, 1);
      check_val("en_c1", chain_en, 0);

      while (done_c == 0 && c < 400) begin
         if (chain_en) begin
            if (din_n < L) din_seq[din_n] = chain_din;
            din_n++;
            en_n++;
         end
         if (done) begin
            done_c = c;
         end else begin
            if (stall_left > 0 && word_ready) begin
               word_valid = 1'b0;
               stall_left--;
            end else begin
               word_valid = 1'b1;
               word_data  = (idx < NW) ? words[idx] : W'($urandom);
            end
            if (word_valid && word_ready) begin
               idx++;
               if (idx == 1) stall_left = stall_len;
            end
            start = (mid_start && c == 8);
            @(negedge prog_clk);
            c++;
         end
      end
      word_valid = 1'b0;
      start = 1'b0;

      check_val("done_cyc", done_c, exp_done);
      check_val("words_acc", idx, NW);
      check_val("din_seq", din_seq, exp_bits);
      check_val("en_count", en_n, L + RB * L);
      if (!inject) check_val("image", chain_q, exp_img);
      check_val("error", error, inject);
      check_val("ready_end", word_ready, 0);
      check_val("busy_end", busy, 0);
      check_val("en_end", chain_en, 0);
      repeat (2) @(negedge prog_clk);
      check_val("done_stky", done, 1);
      check_val("err_stky", error, inject);
      inject_flip = 1'b0;
      $display("load %0d: words=%h %h %h stall=%0d inj=%0d mid_start=%0d done_cyc=%0d err=%0d",
               n, words[0], words[1], words[2], stall_len, inject, mid_start, done_c, error);
   endtask

   // Reset applied after 10 LOAD bits have been presented.
   task automatic run_reset_mid();
      int c, din_n;
      @(negedge prog_clk);
      start = 1'b1;
      @(negedge prog_clk);
      start = 1'b0;
      c = 1; din_n = 0;
      while (din_n < 10 && c < 100) begin
         word_valid = 1'b1;
         word_data  = W'($urandom);
         @(negedge prog_clk);
         c++;
         if (chain_en) din_n++;
      end
      check_val("rst_reach", din_n, 10);
      prog_rst = 1'b1;
      word_valid = 1'b0;
      @(negedge prog_clk);
      check_val("rst_ready", word_ready, 0);
      check_val("rst_en", chain_en, 0);
      check_val("rst_din", chain_din, 0);
      check_val("rst_busy", busy, 0);
      check_val("rst_done", done, 0);
      check_val("rst_error", error, 0);
      prog_rst = 1'b0;
      @(negedge prog_clk);
      check_val("idle_busy", busy, 0);
      $display("reset mid-load after %0d bits: outputs cleared", din_n);
   endtask

   initial begin
      prog_rst   = 1'b1;
      start      = 1'b0;
      word_valid = 1'b0;
      word_data  = '0;
      repeat (3) @(negedge prog_clk);
      check_val("r_ready", word_ready, 0);
      check_val("r_en", chain_en, 0);
      check_val("r_din", chain_din, 0);
      check_val("r_busy", busy, 0);
      check_val("r_done", done, 0);
      check_val("r_error", error, 0);
      prog_rst = 1'b0;
      @(negedge prog_clk);
      check_val("idle_ready", word_ready, 0);

      run_load(0, 1'b1, 0, 1'b0, 1'b0);
      for (int i = 1; i <= 4; i++) begin
         run_load(i, 1'b0, (i == 2) ? 3 : 0, 1'b0, 1'b0);
      end
      run_load(5, 1'b1, 5, 1'b0, 1'b0);
      run_load(6, 1'b0, 0, 1'b0, 1'b1);
      run_reset_mid();
      run_load(7, 1'b0, 0, 1'b0, 1'b0);
`ifdef CFG_READBACK_EN
      run_load(8, 1'b1, 0, 1'b1, 1'b0);
      run_load(9, 1'b0, 2, 1'b0, 1'b0);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
